mig_app_responder: RTL and testbench



---
 rtl/mig_app_responder_if.sv | 33 +++
 rtl/mig_app_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_mig_app_responder.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mig_app_responder_if.sv
// MIG user-interface bundle: command, write-data and read-return channels.
// The controller side drives commands/data; the responder drives ready and read return.
interface mig_app_responder_if #(
  parameter int CHUNK_PART   = 128,
  parameter int ADDRESS_SIZE = 28
);
  logic [ADDRESS_SIZE-1:0]  app_addr;
  logic [2:0]               app_cmd;
  logic                     app_en;
  logic                     app_rdy;
  logic [CHUNK_PART-1:0]    app_wdf_data;
  logic [CHUNK_PART/8-1:0]  app_wdf_mask;
  logic                     app_wdf_wren;
  logic                     app_wdf_end;
  logic                     app_wdf_rdy;
  logic [CHUNK_PART-1:0]    app_rd_data;
  logic                     app_rd_data_valid;
  logic                     app_rd_data_end;

  modport master (
    output app_addr, app_cmd, app_en,
    output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy,
    input  app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport slave (
    input  app_addr, app_cmd, app_en,
    input  app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy,
    output app_rd_data, app_rd_data_valid, app_rd_data_end
  );
endinterface

// File: rtl/mig_app_responder.sv
// Behavioural stand-in for a MIG DDR controller user interface: calibration delay,
// 2-deep write-data FIFO, byte-masked line memory and fixed-latency read return.
module mig_app_responder #(
  parameter int CHUNK_PART       = 128,
  parameter int ADDRESS_SIZE     = 28,
  parameter int DEPTH            = 64,
  parameter int READ_LATENCY     = 4,
  parameter int CALIB_CYCLES     = 16,
  parameter int RDY_STALL_PERIOD = 0
) (
  input  logic                 mig_ui_clk,
  input  logic                 rst_n,
  mig_app_responder_if.slave   app,
  output logic                 init_calib_complete,
  output logic [1:0]           error
);

  localparam int unsigned NB = CHUNK_PART / 8;
  localparam int unsigned RL = READ_LATENCY;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(CALIB_CYCLES + 1) + 1;
  localparam int SW = (RDY_STALL_PERIOD > 1) ? $clog2(RDY_STALL_PERIOD) : 1;
  localparam logic [CW-1:0] CALIB_LAST = CW'((CALIB_CYCLES > 0) ? CALIB_CYCLES - 1 : 0);
  localparam logic [SW-1:0] STALL_LAST = SW'((RDY_STALL_PERIOD > 0) ? RDY_STALL_PERIOD - 1 : 0);
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic {
    WR_IDLE,
    WR_WAIT_BEAT
  } wr_state_e;

  logic [CW-1:0]          calib_cnt;
  logic                   calib_done;
  logic [SW-1:0]          stall_cnt;
  logic                   stall_slot;

  logic [CHUNK_PART-1:0]  fifo_data [2];
  logic [NB-1:0]          fifo_mask [2];
  logic [1:0]             fifo_cnt;

  wr_state_e              wr_state, wr_state_nx;
  logic [IW-1:0]          pend_idx;
  logic                   pend_bad;

  logic [CHUNK_PART-1:0]  mem [DEPTH];

  logic                   rd_v [RL];
  logic [CHUNK_PART-1:0]  rd_d [RL];
  logic                   stage_v_in [RL];
  logic [CHUNK_PART-1:0]  stage_d_in [RL];

  logic                   cmd_fire, wr_acc, rd_acc, illegal_acc;
  logic [IW-1:0]          addr_idx;
  logic                   addr_bad;
  logic                   beat_in, beat_avail;
  logic                   commit_en, commit_bad, pend_load;
  logic [IW-1:0]          commit_idx;
  logic [CHUNK_PART-1:0]  commit_data;
  logic [NB-1:0]          commit_mask;
  logic                   fifo_push, fifo_pop;

  // ---------------- calibration and ready generation ----------------
  always_ff @(posedge mig_ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      calib_cnt  <= '0;
      calib_done <= 1'b0;
    end else if (!calib_done) begin
      calib_cnt <= calib_cnt + 1'b1;
      if (calib_cnt == CALIB_LAST) calib_done <= 1'b1;
    end
  end

  always_ff @(posedge mig_ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (RDY_STALL_PERIOD > 1) begin
      stall_cnt <= (stall_cnt == STALL_LAST) ? '0 : stall_cnt + 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end

  assign stall_slot          = (RDY_STALL_PERIOD != 0) && (stall_cnt == STALL_LAST);
  assign init_calib_complete = calib_done;
  assign app.app_rdy         = calib_done && (wr_state == WR_IDLE) && !stall_slot;
  assign app.app_wdf_rdy     = calib_done && (fifo_cnt != 2'd2);

  // ---------------- command decode ----------------
  assign addr_idx = app.app_addr[3 +: IW];
  assign addr_bad = (app.app_addr[2:0] != 3'b000) || (|app.app_addr[ADDRESS_SIZE-1:3+IW]);

  // Write path: a write either commits immediately (FIFO head, else same-cycle
  // beat bypass) or parks its address until the next beat shows up.
  always_comb begin
    wr_state_nx = wr_state;
    cmd_fire    = app.app_en && app.app_rdy;
    wr_acc      = cmd_fire && (app.app_cmd == CMD_WRITE);
    rd_acc      = cmd_fire && (app.app_cmd == CMD_READ);
    illegal_acc = cmd_fire && !wr_acc && !rd_acc;
    beat_in     = app.app_wdf_wren && app.app_wdf_rdy;
    beat_avail  = (fifo_cnt != 2'd0) || beat_in;
    commit_en   = 1'b0;
    pend_load   = 1'b0;
    commit_idx  = addr_idx;
    commit_bad  = addr_bad;
    commit_data = (fifo_cnt != 2'd0) ? fifo_data[0] : app.app_wdf_data;
    commit_mask = (fifo_cnt != 2'd0) ? fifo_mask[0] : app.app_wdf_mask;
    case (wr_state)
      WR_IDLE: begin
        if (wr_acc) begin
          if (beat_avail) begin
            commit_en = 1'b1;
          end else begin
            pend_load   = 1'b1;
            wr_state_nx = WR_WAIT_BEAT;
          end
        end
      end
      WR_WAIT_BEAT: begin
        commit_idx = pend_idx;
        commit_bad = pend_bad;
        if (beat_avail) begin
          commit_en   = 1'b1;
          wr_state_nx = WR_IDLE;
        end
      end
      default: wr_state_nx = WR_IDLE;
    endcase
    fifo_pop  = commit_en && (fifo_cnt != 2'd0);
    fifo_push = beat_in && !(commit_en && (fifo_cnt == 2'd0));
  end

  always_ff @(posedge mig_ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WR_IDLE;
      pend_idx <= '0;
      pend_bad <= 1'b0;
    end else begin
      wr_state <= wr_state_nx;
      if (pend_load) begin
        pend_idx <= addr_idx;
        pend_bad <= addr_bad;
      end
    end
  end

  // ---------------- write-data FIFO (slot 0 is the head) ----------------
  always_ff @(posedge mig_ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt     <= '0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_mask[0] <= '0;
      fifo_mask[1] <= '0;
    end else begin
      case ({fifo_push, fifo_pop})
        2'b10: begin
          fifo_data[fifo_cnt[0]] <= app.app_wdf_data;
          fifo_mask[fifo_cnt[0]] <= app.app_wdf_mask;
          fifo_cnt               <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          fifo_data[0] <= fifo_data[1];
          fifo_mask[0] <= fifo_mask[1];
          fifo_cnt     <= fifo_cnt - 2'd1;
        end
        // Push alongside pop only happens with one entry queued, so the
        // incoming beat simply replaces the consumed head.
        2'b11: begin
          fifo_data[0] <= app.app_wdf_data;
          fifo_mask[0] <= app.app_wdf_mask;
        end
        default: ;
      endcase
    end
  end

  // ---------------- line memory (contents survive reset) ----------------
  always_ff @(posedge mig_ui_clk) begin
    if (commit_en && !commit_bad) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (!commit_mask[b]) mem[commit_idx][b*8 +: 8] <= commit_data[b*8 +: 8];
      end
    end
  end

  // ---------------- read pipeline ----------------
  // Data registers only load alongside a valid, so the last stage holds the
  // most recent return between pulses.
  always_comb begin
    stage_v_in[0] = rd_acc;
    stage_d_in[0] = addr_bad ? '0 : mem[addr_idx];
    for (int unsigned s = 1; s < RL; s++) begin
      stage_v_in[s] = rd_v[s-1];
      stage_d_in[s] = rd_d[s-1];
    end
  end

  always_ff @(posedge mig_ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < RL; s++) begin
        rd_v[s] <= 1'b0;
        rd_d[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < RL; s++) begin
        rd_v[s] <= stage_v_in[s];
        if (stage_v_in[s]) rd_d[s] <= stage_d_in[s];
      end
    end
  end

  assign app.app_rd_data       = rd_d[RL-1];
  assign app.app_rd_data_valid = rd_v[RL-1];
  assign app.app_rd_data_end   = rd_v[RL-1];

  // ---------------- sticky error flags ----------------
  always_ff @(posedge mig_ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      error <= '0;
    end else begin
      error <= error | {(wr_acc || rd_acc) && addr_bad, illegal_acc};
    end
  end

  wdf_end_tracks_wren: assert property (
    @(posedge mig_ui_clk) disable iff (!rst_n) app.app_wdf_end == app.app_wdf_wren
  );

endmodule

// File: tb/tb_mig_app_responder.sv
// Randomized scoreboard bench for mig_app_responder: a queue-based memory model
// predicts ready, error and read-return behaviour; a monitor checks every read return.
module tb_mig_app_responder;
  localparam int CP    = 128;
  localparam int AS    = 28;
  localparam int DEPTH = 64;
  localparam int RL    = 4;
  localparam int CALIB = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mig_app_responder_if #(.CHUNK_PART(CP), .ADDRESS_SIZE(AS)) app ();
  mig_app_responder_if #(.CHUNK_PART(CP), .ADDRESS_SIZE(AS)) app_s ();
  logic       calib, calib_s;
  logic [1:0] err, err_s;

  mig_app_responder #(
    .CHUNK_PART(CP), .ADDRESS_SIZE(AS), .DEPTH(DEPTH), .READ_LATENCY(RL),
    .CALIB_CYCLES(CALIB), .RDY_STALL_PERIOD(0)
  ) dut (
    .mig_ui_clk(clk), .rst_n(rst_n), .app(app),
    .init_calib_complete(calib), .error(err)
  );

  mig_app_responder #(
    .CHUNK_PART(CP), .ADDRESS_SIZE(AS), .DEPTH(DEPTH), .READ_LATENCY(RL),
    .CALIB_CYCLES(CALIB), .RDY_STALL_PERIOD(4)
  ) dut_s (
    .mig_ui_clk(clk), .rst_n(rst_n), .app(app_s),
    .init_calib_complete(calib_s), .error(err_s)
  );

  int checks = 0;
  int errors = 0;
  int edges;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges = 0;
    else        edges = edges + 1;
  end

  task automatic chk(input string name, input logic [CP-1:0] act, input logic [CP-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic bad; int idx; }              wcmd_t;
  typedef struct { logic [CP-1:0] d; logic [15:0] m; } beat_t;
  typedef struct { logic [CP-1:0] d; int due; }        exp_t;

  logic [CP-1:0] ref_mem [DEPTH];
  wcmd_t         wq[$];
  beat_t         bq[$];
  exp_t          exp_q[$];
  logic [1:0]    err_m = 2'b00;

  // Write commands and data beats pair up strictly in arrival order.
  task automatic pair_up();
    wcmd_t w;
    beat_t b;
    while (wq.size() > 0 && bq.size() > 0) begin
      w = wq.pop_front();
      b = bq.pop_front();
      if (!w.bad)
        for (int k = 0; k < CP/8; k++)
          if (!b.m[k]) ref_mem[w.idx][k*8 +: 8] = b.d[k*8 +: 8];
    end
  endtask

  task automatic cyc(input logic en, input logic [2:0] cmd, input int addr,
                     input logic wren, input logic [CP-1:0] d, input logic [15:0] m);
    logic calib_m, rdy_m, wrdy_m, bad;
    wcmd_t w;
    beat_t b;
    exp_t  e;
    @(negedge clk);
    app.app_en       = en;
    app.app_cmd      = cmd;
    app.app_addr     = AS'(addr);
    app.app_wdf_wren = wren;
    app.app_wdf_end  = wren;
    app.app_wdf_data = d;
    app.app_wdf_mask = m;
    calib_m = (edges >= CALIB);
    rdy_m   = calib_m && (wq.size() == 0);
    wrdy_m  = calib_m && (bq.size() < 2);
    chk_i("init_calib_complete", int'(calib), int'(calib_m));
    chk_i("app_rdy", int'(app.app_rdy), int'(rdy_m));
    chk_i("app_wdf_rdy", int'(app.app_wdf_rdy), int'(wrdy_m));
    if (en && rdy_m) begin
      bad = (addr % 8 != 0) || (addr / 8 >= DEPTH);
      if (cmd == 3'b000) begin
        w.bad = bad;
        w.idx = bad ? 0 : addr / 8;
        wq.push_back(w);
        if (bad) err_m[1] = 1'b1;
      end else if (cmd == 3'b001) begin
        e.d   = bad ? '0 : ref_mem[addr / 8];
        e.due = edges + RL;
        exp_q.push_back(e);
        if (bad) err_m[1] = 1'b1;
      end else begin
        err_m[0] = 1'b1;
      end
    end
    if (wren && wrdy_m) begin
      b.d = d;
      b.m = m;
      bq.push_back(b);
    end
    pair_up();
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'b000, 0, 1'b0, '0, 16'h0);
  endtask

  task automatic wr(input int addr, input logic [CP-1:0] d, input logic [15:0] m);
    cyc(1'b1, 3'b000, addr, 1'b1, d, m);
  endtask

  task automatic rd(input int addr);
    cyc(1'b1, 3'b001, addr, 1'b0, '0, 16'h0);
  endtask

  function automatic logic [CP-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- read-return monitor ----------------
  logic [CP-1:0] last_rd = '0;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_rd = '0;
    end else if (app.app_rd_data_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid: got data %0h expected no return (t=%0t)",
                 app.app_rd_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_data", app.app_rd_data, mon_e.d);
        chk_i("rd_latency", edges, mon_e.due);
        chk_i("rd_data_end", int'(app.app_rd_data_end), 1);
        last_rd = mon_e.d;
      end
    end else begin
      chk_i("rd_data_end_idle", int'(app.app_rd_data_end), 0);
      chk("rd_data_hold", app.app_rd_data, last_rd);
    end
  end

  // ---------------- stall-slot instance ----------------
  initial begin
    app_s.app_en = 1'b0;  app_s.app_cmd = 3'b000;  app_s.app_addr = '0;
    app_s.app_wdf_wren = 1'b0;  app_s.app_wdf_end = 1'b0;
    app_s.app_wdf_data = '0;  app_s.app_wdf_mask = '0;
    @(posedge rst_n);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      chk_i("stall_app_rdy", int'(app_s.app_rdy), int'((edges >= CALIB) && (edges % 4 != 3)));
    end
    chk_i("stall_calib", int'(calib_s), 1);
    chk_i("stall_error", int'(err_s), 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached with %0d checks, %0d errors", checks, errors);
    $fatal(1, "simulation timeout");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int a, r;
    logic [15:0] m;
    app.app_en = 1'b0;  app.app_cmd = 3'b000;  app.app_addr = '0;
    app.app_wdf_wren = 1'b0;  app.app_wdf_end = 1'b0;
    app.app_wdf_data = '0;  app.app_wdf_mask = '0;

    repeat (3) @(negedge clk);
    chk_i("rst_calib", int'(calib), 0);
    chk_i("rst_app_rdy", int'(app.app_rdy), 0);
    chk_i("rst_app_wdf_rdy", int'(app.app_wdf_rdy), 0);
    chk_i("rst_rd_valid", int'(app.app_rd_data_valid), 0);
    chk_i("rst_rd_end", int'(app.app_rd_data_end), 0);
    chk("rst_rd_data", app.app_rd_data, '0);
    chk_i("rst_error", int'(err), 0);
    rst_n = 1'b1;

    idle(20);

    wr(200, 128'h12345678, 16'h0000);
    rd(200);
    idle(6);

    wr(96, 128'hCAFEBABE, 16'h0000);
    wr(96, 128'hFFFFFFFF, 16'hFFFE);
    rd(96);
    idle(6);

    cyc(1'b1, 3'b000, 40, 1'b0, '0, 16'h0);
    idle(3);
    cyc(1'b0, 3'b000, 0, 1'b1, 128'hA5A5_0123_4567_89AB_CDEF_0011_2233_4455, 16'h0000);
    rd(40);
    rd(200);
    rd(96);
    rd(40);
    idle(8);

    cyc(1'b0, 3'b000, 0, 1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 16'h0000);
    cyc(1'b0, 3'b000, 0, 1'b1, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 16'h00FF);
    idle(1);
    cyc(1'b1, 3'b000, 200, 1'b0, '0, 16'h0);
    cyc(1'b1, 3'b000, 96, 1'b0, '0, 16'h0);
    rd(200);
    rd(96);
    idle(8);

    chk_i("error_clean", int'(err), int'(err_m));
    rd(100);
    rd(DEPTH * 8);
    idle(6);
    chk_i("error_bad_addr", int'(err), int'(err_m));
    cyc(1'b1, 3'b011, 0, 1'b0, '0, 16'h0);
    idle(2);
    chk_i("error_illegal_cmd", int'(err), int'(err_m));

    for (int i = 0; i < DEPTH; i++) wr(i * 8, rnd_data(), 16'h0000);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      a = $urandom_range(0, DEPTH - 1) * 8;
      if ($urandom_range(0, 19) == 0) a = a + $urandom_range(1, 7);
      if ($urandom_range(0, 29) == 0) a = DEPTH * 8 + $urandom_range(0, 255) * 8;
      m = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom_range(0, 65535));
      case (r)
        0, 1, 2, 3: cyc(1'b1, 3'b000, a, 1'b1, rnd_data(), m);
        4:          cyc(1'b1, 3'b000, a, 1'b0, '0, 16'h0);
        5:          cyc(1'b0, 3'b000, 0, 1'b1, rnd_data(), m);
        6, 7, 8:    rd(a);
        default: begin
          if ($urandom_range(0, 3) == 0) cyc(1'b1, 3'($urandom_range(2, 7)), a, 1'b0, '0, 16'h0);
          else idle(1);
        end
      endcase
    end
    for (int k = 0; k < 4 && wq.size() > 0; k++) cyc(1'b0, 3'b000, 0, 1'b1, rnd_data(), 16'h0000);
    idle(10);
    chk_i("all_reads_returned", exp_q.size(), 0);
    chk_i("error_after_random", int'(err), int'(err_m));

    rd(40);
    idle(1);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    wq.delete();
    bq.delete();
    err_m = 2'b00;
    @(negedge clk);
    chk_i("midrst_rd_valid", int'(app.app_rd_data_valid), 0);
    chk_i("midrst_app_rdy", int'(app.app_rdy), 0);
    chk_i("midrst_calib", int'(calib), 0);
    chk_i("midrst_error", int'(err), 0);
    chk("midrst_rd_data", app.app_rd_data, '0);
    @(negedge clk);
    chk_i("midrst_rd_valid_late", int'(app.app_rd_data_valid), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 3'b000, 0, 1'b0, '0, 16'h0);
      chk_i("postrst_no_valid", int'(app.app_rd_data_valid), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
